// File: rtl/bsram_sd_ctrl.sv
// Moves the BSRAM save image between the SD sector interface and the BSRAM region of SDRAM, one 512-byte sector at a time.
// Each byte takes at least 3 cycles (buffer access, memory request, ack); each sector then adds the SD transfer time.
// Stalls on sd_ack and on the mem_req/mem_ack toggle handshake; only one memory access is outstanding at a time.
module bsram_sd_ctrl #(
    parameter int ADDR_W = 20
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic [23:0]       ram_mask,
    input  logic              img_mounted,
    input  logic [31:0]       img_size,
    input  logic              save_req,
    output logic [31:0]       sd_lba,
    output logic              sd_rd,
    output logic              sd_wr,
    input  logic              sd_ack,
    input  logic [8:0]        sd_buff_addr,
    input  logic [7:0]        sd_buff_dout,
    input  logic              sd_buff_wr,
    output logic [7:0]        sd_buff_din,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_req,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_COPY_OUT,
        S_WR_FILL,
        S_WR_REQ,
        S_WR_WAIT,
        S_NEXT
    } state_t;

    typedef enum logic [1:0] {
        P_BUF,
        P_REQ,
        P_WAIT
    } phase_t;

    state_t r_state;
    state_t w_state_nxt;
    phase_t r_ph;
    phase_t w_ph_nxt;

    logic              r_mounted;
    logic              r_load_pend;
    logic              r_save_pend;
    logic              r_is_save;
    logic [22:0]       r_n_img;
    logic [23:0]       r_count;
    logic [23:0]       r_sec;
    logic [8:0]        r_idx;
    logic [31:0]       r_sd_lba;
    logic              r_sd_rd;
    logic              r_sd_wr;
    logic              r_busy;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_mem_wdata;
    logic              r_mem_we;
    logic              r_mem_req;
    logic [7:0]        r_bdat;
    logic [7:0]        r_cap;
    logic [7:0]        r_sd_din;
    logic [7:0]        r_buf [0:511];

    logic [23:0]       w_n_ram;
    logic [23:0]       w_n_img;
    logic [23:0]       w_load_cnt;
    logic              w_mem_idle;
    logic [ADDR_W-1:0] w_addr;
    logic              w_last_byte;
    logic              w_last_sec;
    logic              w_take_load;
    logic              w_take_save;
    logic              w_drop_load;
    logic              w_issue;
    logic              w_idx_inc;
    logic              w_buf_we;
    logic              w_cap;

    assign w_n_ram     = {9'd0, ram_mask[23:9]} + 24'd1;
    assign w_n_img     = {1'b0, r_n_img};
    assign w_load_cnt  = (w_n_img < w_n_ram) ? w_n_img : w_n_ram;
    assign w_mem_idle  = (r_mem_req == mem_ack);
    // Masking keeps an oversized image from ever addressing outside the BSRAM.
    assign w_addr      = ADDR_W'({r_sec, r_idx}) & ram_mask[ADDR_W-1:0];
    assign w_last_byte = (r_idx == 9'd511);
    assign w_last_sec  = ((r_sec + 24'd1) == r_count);

    assign sd_lba      = r_sd_lba;
    assign sd_rd       = r_sd_rd;
    assign sd_wr       = r_sd_wr;
    assign sd_buff_din = r_sd_din;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign mem_we      = r_mem_we;
    assign mem_req     = r_mem_req;
    assign busy        = r_busy;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_ph    <= P_BUF;
        end else begin
            r_state <= w_state_nxt;
            r_ph    <= w_ph_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ph_nxt    = r_ph;
        w_take_load = 1'b0;
        w_take_save = 1'b0;
        w_drop_load = 1'b0;
        w_issue     = 1'b0;
        w_idx_inc   = 1'b0;
        w_buf_we    = 1'b0;
        w_cap       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_load_pend) begin
                    // No BSRAM or less than one whole sector of image: nothing to load.
                    if (ram_mask == 24'd0 || w_load_cnt == 24'd0) begin
                        w_drop_load = 1'b1;
                    end else begin
                        w_take_load = 1'b1;
                        w_state_nxt = S_RD_REQ;
                    end
                end else if (r_save_pend) begin
                    w_take_save = 1'b1;
                    w_state_nxt = S_WR_FILL;
                    w_ph_nxt    = P_REQ;
                end
            end
            S_RD_REQ: begin
                if (sd_ack) w_state_nxt = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (!sd_ack) begin
                    w_state_nxt = S_COPY_OUT;
                    w_ph_nxt    = P_BUF;
                end
            end
            S_COPY_OUT: begin
                case (r_ph)
                    P_BUF: w_ph_nxt = P_REQ;
                    P_REQ: begin
                        if (w_mem_idle) begin
                            w_issue  = 1'b1;
                            w_ph_nxt = P_WAIT;
                        end
                    end
                    P_WAIT: begin
                        if (w_mem_idle) begin
                            if (w_last_byte) begin
                                w_state_nxt = S_NEXT;
                            end else begin
                                w_idx_inc = 1'b1;
                                w_ph_nxt  = P_BUF;
                            end
                        end
                    end
                    default: w_ph_nxt = P_BUF;
                endcase
            end
            S_WR_FILL: begin
                case (r_ph)
                    P_REQ: begin
                        if (w_mem_idle) begin
                            w_issue  = 1'b1;
                            w_ph_nxt = P_WAIT;
                        end
                    end
                    P_WAIT: begin
                        if (w_mem_idle) begin
                            w_cap    = 1'b1;
                            w_ph_nxt = P_BUF;
                        end
                    end
                    P_BUF: begin
                        w_buf_we = 1'b1;
                        if (w_last_byte) begin
                            w_state_nxt = S_WR_REQ;
                        end else begin
                            w_idx_inc = 1'b1;
                            w_ph_nxt  = P_REQ;
                        end
                    end
                    default: w_ph_nxt = P_REQ;
                endcase
            end
            S_WR_REQ: begin
                if (sd_ack) w_state_nxt = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (!sd_ack) w_state_nxt = S_NEXT;
            end
            S_NEXT: begin
                if (w_last_sec) begin
                    w_state_nxt = S_IDLE;
                end else if (r_is_save) begin
                    w_state_nxt = S_WR_FILL;
                    w_ph_nxt    = P_REQ;
                end else begin
                    w_state_nxt = S_RD_REQ;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_ph_nxt    = P_BUF;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_mounted   <= 1'b0;
            r_load_pend <= 1'b0;
            r_save_pend <= 1'b0;
            r_is_save   <= 1'b0;
            r_n_img     <= 23'd0;
            r_count     <= 24'd0;
            r_sec       <= 24'd0;
            r_idx       <= 9'd0;
            r_sd_lba    <= 32'd0;
            r_sd_rd     <= 1'b0;
            r_sd_wr     <= 1'b0;
            r_busy      <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 8'd0;
            r_mem_we    <= 1'b0;
            r_mem_req   <= 1'b0;
            r_cap       <= 8'd0;
        end else begin
            if (img_mounted) begin
                r_mounted <= 1'b1;
                r_n_img   <= img_size[31:9];
            end

            // A new pulse wins over the clear so a request arriving while busy is never lost.
            if (img_mounted && img_size != 32'd0) begin
                r_load_pend <= 1'b1;
            end else if (w_take_load || w_drop_load) begin
                r_load_pend <= 1'b0;
            end

            if (save_req && (r_mounted || img_mounted) && ram_mask != 24'd0) begin
                r_save_pend <= 1'b1;
            end else if (w_take_save) begin
                r_save_pend <= 1'b0;
            end

            if (w_take_load) begin
                r_count   <= w_load_cnt;
                r_is_save <= 1'b0;
            end else if (w_take_save) begin
                r_count   <= w_n_ram;
                r_is_save <= 1'b1;
            end

            if (r_state == S_IDLE) begin
                r_sec    <= 24'd0;
                r_sd_lba <= 32'd0;
            end else if (r_state == S_NEXT) begin
                r_sec    <= r_sec + 24'd1;
                r_sd_lba <= r_sd_lba + 32'd1;
            end

            if (r_state == S_IDLE || r_state == S_RD_WAIT || r_state == S_NEXT) begin
                r_idx <= 9'd0;
            end else if (w_idx_inc) begin
                r_idx <= r_idx + 9'd1;
            end

            r_sd_rd <= (w_state_nxt == S_RD_REQ);
            r_sd_wr <= (w_state_nxt == S_WR_REQ);
            r_busy  <= (w_state_nxt != S_IDLE);

            if (w_issue) begin
                r_mem_addr <= w_addr;
                r_mem_we   <= (r_state == S_COPY_OUT);
                r_mem_req  <= ~r_mem_req;
                if (r_state == S_COPY_OUT) r_mem_wdata <= r_bdat;
            end

            if (w_cap) r_cap <= mem_rdata;
        end
    end

    // Sector buffer: the SD side writes only while loading, the copy engine only while saving.
    always_ff @(posedge clk_sys) begin
        if (sd_buff_wr) r_buf[sd_buff_addr] <= sd_buff_dout;
        if (w_buf_we) r_buf[r_idx] <= r_cap;
        r_bdat <= r_buf[r_idx];
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_sd_din <= 8'd0;
        end else begin
            r_sd_din <= r_buf[sd_buff_addr];
        end
    end

endmodule
